scarv_cop_regfile: RTL and testbench
====================================

Name: scarv_cop_regfile

Overview:
- Parametrised general-purpose register file for the COP, next generation of the coprocessor register store.
- Configurable data width, register count and number of read ports.
- Byte-lane write enables and optional write-to-read bypass.
- A proper init/clear state machine with a busy/done handshake, serving xc.init and any future bulk-clear.

Parameters:
XLEN, 32, register width in bits; must be a multiple of 8
NREGS, 16, number of registers; power of two, >= 2
NRD, 3, number of read ports
BYPASS, 1, 1 = same-cycle write data is forwarded to matching reads
CLR_PER_CYC, 1, registers cleared per init cycle; power of two, divides NREGS
AW, $clog2(NREGS), address width (derived; not to be overridden)

Ports:
g_clk  in  1  global clock
g_resetn  in  1  synchronous active-low reset
g_clk_req  out  1  clock request
init_req  in  1  level request to clear all registers to zero
init_busy  out  1  clear sequence in progress
init_done  out  1  clear complete; held while init_req stays high
rd_ren  in  NRD  per-port read enable
rd_addr  in  NRD*AW  per-port address; port i at [i*AW +: AW]
rd_rdata  out  NRD*XLEN  per-port read data; port i at [i*XLEN +: XLEN]
wr_wen  in  XLEN/8  byte-lane write enables
wr_addr  in  AW  write address
wr_wdata  in  XLEN  write data
wr_ready  out  1  write port accepts writes; low while init_busy

Behaviour:
- Reset is g_resetn, synchronous, active-low, on clock g_clk.
  - Reset forces the FSM to IDLE and the clear counter to 0.
  - Register storage is not reset.
- Outputs in reset and after it: init_busy=0, init_done=0, wr_ready=1, g_clk_req=0. rd_rdata is 0 for any port whose rd_ren is 0.
- Read ports are combinational, with 0-cycle latency.
  - rd_rdata[i] = {XLEN{rd_ren[i]}} & reg[rd_addr[i]].
  - Reading an address that has not been written since power-up returns X. Benches must init first.
- Write takes effect at the rising edge:
  - For each lane b with wr_wen[b]=1 and wr_ready=1, reg[wr_addr] byte b <= wr_wdata byte b.
  - Other lanes are untouched.
- Bypass (BYPASS=1):
  - Applies when rd_ren[i]=1, rd_addr[i]==wr_addr, wr_ready=1 and wr_wen[b]=1.
  - For each such lane b, rd_rdata[i] byte b = wr_wdata byte b in the same cycle.
  - Lanes not being written return stored data.
  - With BYPASS=0 the read returns the old value.
- Init FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR when init_req=1. The counter is 0 on entry.
  - CLEAR:
    - init_busy=1 and wr_ready=0.
    - Each cycle, registers counter*CLR_PER_CYC .. counter*CLR_PER_CYC+CLR_PER_CYC-1 are written with 0 (all lanes), and the counter increments.
    - On the last group (counter == NREGS/CLR_PER_CYC-1), go to DONE.
    - Clear duration is exactly NREGS/CLR_PER_CYC cycles.
  - DONE: init_done=1 and init_busy=0. Stay while init_req=1. Go to IDLE the cycle after init_req falls.
  - init_req falling during CLEAR: abort to IDLE next cycle. Registers already cleared stay cleared; the rest keep old values. init_done never asserts.
  - A new init_req after an abort restarts from counter 0.
- Writes presented while wr_ready=0 are dropped, not queued. The producer must hold the write until wr_ready=1.
- Bypass is suppressed while wr_ready=0. Reads during CLEAR return current storage, including freshly cleared zeros.
- Reset mid-CLEAR: return to IDLE immediately. Partial clear stays as-is.
- g_clk_req = (|wr_wen) | init_req | init_busy | init_done.
- Address ranges: all addresses are in range by construction, since NREGS is a power of two. There is no wrap handling beyond AW truncation.

Decomposition:
- Shared package scarv_cop_pkg holds:
  - the FSM state encoding (IDLE=2'd0, CLEAR=2'd1, DONE=2'd2);
  - the byte-lane count macro XLEN/8;
  - default XLEN/NREGS constants reused by the COP top.
- One natural sub-module, scarv_cop_regfile_clr_fsm: init FSM plus clear counter, producing clear_en, clear_base, init_busy and init_done.
- Storage, read muxes and bypass stay in the parent.

Test Plan:
1. Defaults: init_req=1 for 16+2 cycles -> init_busy high for exactly 16 cycles, then init_done=1. All 16 registers read 0x00000000 on all 3 ports.
2. After init, write addr 5 with data 0xDEADBEEF, wr_wen=4'b0101 -> next cycle, reading addr 5 returns 0x00AD00EF. Ports with rd_ren=0 return 0.
3. BYPASS=1: reg 3=0x11223344, same cycle write addr 3 with 0xAABBCCDD, wr_wen=4'b1000, read port 1 at addr 3 -> rd_rdata[1]=0xAA223344 that cycle. With BYPASS=0 -> 0x11223344.
4. Write addr 7 while init_busy=1 -> wr_ready=0 and the write is dropped. After DONE, addr 7 reads 0.
5. init_req drops after 4 CLEAR cycles (regs pre-filled 0xFFFFFFFF) -> IDLE next cycle. Regs 0-3 read 0 and regs 4-15 read 0xFFFFFFFF. init_done never pulses.
6. CLR_PER_CYC=4, NREGS=16: clear completes in 4 cycles. Assert g_resetn=0 on cycle 2 -> FSM is in IDLE and init_busy=0 the next cycle, and regs 0-7 are cleared.

Source files
------------

// File: rtl/scarv_cop_pkg.sv
// ---------------------------------------------------------------------------
// scarv_cop_pkg
//   Shared definitions for the COP register store:
//     - default COP data width and register count
//     - byte-lane count helper
//     - init/clear FSM state encoding
// ---------------------------------------------------------------------------
package scarv_cop_pkg;

    localparam int COP_XLEN  = 32;
    localparam int COP_NREGS = 16;

    // Number of byte lanes in an xlen-bit word.
    function automatic int cop_lanes(input int xlen);
        return xlen / 8;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/scarv_cop_regfile_clr_fsm.sv
// ---------------------------------------------------------------------------
// scarv_cop_regfile_clr_fsm
//   Init/clear sequencer for the COP register file. Walks the register file
//   in groups of CLR_PER_CYC registers while init_req is held, then reports
//   completion until init_req falls. Dropping init_req mid-sequence aborts.
//
// Ports:
//   g_clk       in   clock
//   g_resetn    in   synchronous active-low reset
//   init_req    in   level request to clear all registers
//   clear_en    out  write zeros to the group starting at clear_base
//   clear_base  out  first register of the group being cleared
//   init_busy   out  clear sequence in progress
//   init_done   out  clear complete (held while init_req stays high)
//   state       out  current FSM state (observability)
// ---------------------------------------------------------------------------
module scarv_cop_regfile_clr_fsm
    import scarv_cop_pkg::*;
#(
    parameter  int NREGS       = COP_NREGS,
    parameter  int CLR_PER_CYC = 1,
    localparam int AW          = $clog2(NREGS)
) (
    input  logic          g_clk,
    input  logic          g_resetn,
    input  logic          init_req,
    output logic          clear_en,
    output logic [AW-1:0] clear_base,
    output logic          init_busy,
    output logic          init_done,
    output clr_state_t    state
);

    localparam int NGRP  = NREGS / CLR_PER_CYC;
    localparam int CW    = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int SHIFT = $clog2(CLR_PER_CYC);

    clr_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          last_grp;

    assign last_grp = (cnt == CW'(NGRP - 1));

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (init_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (!init_req) begin
                    // Abort: already-cleared groups stay cleared.
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (last_grp) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                end
            end
            DONE: begin
                if (!init_req) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are qualified by g_resetn so a reset landing mid-clear stops
    // the clear in that very cycle and reopens the write port immediately.
    assign clear_en   = g_resetn && (state == CLEAR) && init_req;
    assign init_busy  = g_resetn && (state == CLEAR);
    assign init_done  = g_resetn && (state == DONE);
    assign clear_base = AW'(32'(cnt) << SHIFT);

endmodule

// File: rtl/scarv_cop_regfile.sv
// ---------------------------------------------------------------------------
// scarv_cop_regfile
//   Parametrised COP general-purpose register file: NRD combinational read
//   ports, one byte-lane-masked write port, optional write-to-read bypass and
//   a bulk clear sequence driven by init_req.
//
// Ports:
//   g_clk      in   clock
//   g_resetn   in   synchronous active-low reset (storage is not reset)
//   g_clk_req  out  clock request
//   init_req   in   level request to clear all registers to zero
//   init_busy  out  clear in progress
//   init_done  out  clear complete, held while init_req high
//   rd_ren     in   per-port read enable
//   rd_addr    in   per-port address, port i at [i*AW +: AW]
//   rd_rdata   out  per-port data, port i at [i*XLEN +: XLEN]; 0 when disabled
//   wr_wen     in   byte-lane write enables
//   wr_addr    in   write address
//   wr_wdata   in   write data
//   wr_ready   out  write port open
//
// Write handshake: a lane is written at the rising edge when wr_wen[b] and
// wr_ready are both high in that cycle. wr_wen is not a request that waits:
// lanes presented while wr_ready is low are dropped, so the producer holds
// the write until it sees wr_ready high.
// ---------------------------------------------------------------------------
module scarv_cop_regfile
    import scarv_cop_pkg::*;
#(
    parameter  int XLEN        = COP_XLEN,
    parameter  int NREGS       = COP_NREGS,
    parameter  int NRD         = 3,
    parameter  int BYPASS      = 1,
    parameter  int CLR_PER_CYC = 1,
    localparam int AW          = $clog2(NREGS)
) (
    input  logic                g_clk,
    input  logic                g_resetn,
    output logic                g_clk_req,
    input  logic                init_req,
    output logic                init_busy,
    output logic                init_done,
    input  logic [NRD-1:0]      rd_ren,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_rdata,
    input  logic [XLEN/8-1:0]   wr_wen,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_wdata,
    output logic                wr_ready
);

    localparam int NLANES = cop_lanes(XLEN);
    // Clears are group aligned: masking off the low bits of a register index
    // gives the base of the group it belongs to.
    localparam logic [AW-1:0] GRP_MASK = ~(AW'(CLR_PER_CYC - 1));

    logic [XLEN-1:0] regs [NREGS];
    logic            clear_en;
    logic [AW-1:0]   clear_base;
    clr_state_t      clr_state;

    scarv_cop_regfile_clr_fsm #(
        .NREGS       (NREGS),
        .CLR_PER_CYC (CLR_PER_CYC)
    ) u_clr_fsm (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .init_req   (init_req),
        .clear_en   (clear_en),
        .clear_base (clear_base),
        .init_busy  (init_busy),
        .init_done  (init_done),
        .state      (clr_state)
    );

    // Write port is closed exactly while the clear sequence owns storage.
    assign wr_ready  = !(g_resetn && (clr_state == CLEAR));

    assign g_clk_req = (|wr_wen) | init_req | init_busy | init_done;

    // Storage. Clearing and normal writes never coincide because wr_ready is
    // low whenever clear_en can be high.
    always_ff @(posedge g_clk) begin
        for (int r = 0; r < NREGS; r++) begin
            if (clear_en && ((AW'(r) & GRP_MASK) == clear_base)) begin
                regs[r] <= '0;
            end else if (wr_ready && (wr_addr == AW'(r))) begin
                for (int b = 0; b < NLANES; b++) begin
                    if (wr_wen[b]) begin
                        regs[r][b*8 +: 8] <= wr_wdata[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Read ports, with per-lane forwarding of the write being accepted this
    // cycle when bypass is enabled.
    always_comb begin
        rd_rdata = '0;
        for (int i = 0; i < NRD; i++) begin
            if (rd_ren[i]) begin
                rd_rdata[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
                if ((BYPASS != 0) && wr_ready && (rd_addr[i*AW +: AW] == wr_addr)) begin
                    for (int b = 0; b < NLANES; b++) begin
                        if (wr_wen[b]) begin
                            rd_rdata[i*XLEN + b*8 +: 8] = wr_wdata[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_scarv_cop_regfile.sv
// ---------------------------------------------------------------------------
// tb_scarv_cop_regfile
//   Two instances share one stimulus stream:
//     dut_a : defaults (BYPASS=1, CLR_PER_CYC=1)
//     dut_b : BYPASS=0, CLR_PER_CYC=4
//   A reference model holds register contents as plain arrays and the clear
//   progress as a count of registers cleared so far.
// ---------------------------------------------------------------------------
module tb_scarv_cop_regfile;

    localparam int XLEN  = 32;
    localparam int NREGS = 16;
    localparam int NRD   = 3;
    localparam int AW    = 4;
    localparam int NL    = 4;

    // ---------------- clock / reset ----------------
    logic g_clk = 1'b0;
    logic g_resetn;
    always #5 g_clk = ~g_clk;

    // ---------------- DUT signals ----------------
    logic                init_req;
    logic [NRD-1:0]      rd_ren;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NL-1:0]       wr_wen;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_wdata;

    logic                clk_req_a, busy_a, done_a, ready_a;
    logic [NRD*XLEN-1:0] rdata_a;
    logic                clk_req_b, busy_b, done_b, ready_b;
    logic [NRD*XLEN-1:0] rdata_b;

    scarv_cop_regfile dut_a (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .g_clk_req (clk_req_a),
        .init_req  (init_req),
        .init_busy (busy_a),
        .init_done (done_a),
        .rd_ren    (rd_ren),
        .rd_addr   (rd_addr),
        .rd_rdata  (rdata_a),
        .wr_wen    (wr_wen),
        .wr_addr   (wr_addr),
        .wr_wdata  (wr_wdata),
        .wr_ready  (ready_a)
    );

    scarv_cop_regfile #(.BYPASS(0), .CLR_PER_CYC(4)) dut_b (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .g_clk_req (clk_req_b),
        .init_req  (init_req),
        .init_busy (busy_b),
        .init_done (done_b),
        .rd_ren    (rd_ren),
        .rd_addr   (rd_addr),
        .rd_rdata  (rdata_b),
        .wr_wen    (wr_wen),
        .wr_addr   (wr_addr),
        .wr_wdata  (wr_wdata),
        .wr_ready  (ready_b)
    );

    // ---------------- reference model ----------------
    logic [XLEN-1:0] mem [2][NREGS];
    int              st [2];         // 0 idle, 1 clearing, 2 done
    int              ncleared [2];   // registers cleared in current sequence
    int              cpc [2]    = '{1, 4};
    int              bypass [2] = '{1, 0};

    // ---------------- scoreboard ----------------
    logic [XLEN-1:0] exp_q[$];
    int              n_checks = 0;
    int              n_fail   = 0;

    task automatic check_val(input string tag, input logic [XLEN-1:0] got,
                             input logic [XLEN-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_busy(input int d);
        return g_resetn && (st[d] == 1);
    endfunction

    function automatic logic model_done(input int d);
        return g_resetn && (st[d] == 2);
    endfunction

    function automatic logic [XLEN-1:0] model_read(input int d, input int p);
        logic [XLEN-1:0] v;
        logic [AW-1:0]   a;
        if (!rd_ren[p]) return '0;
        a = rd_addr[p*AW +: AW];
        v = mem[d][a];
        if (bypass[d] != 0 && !model_busy(d) && a == wr_addr)
            for (int b = 0; b < NL; b++)
                if (wr_wen[b]) v[b*8 +: 8] = wr_wdata[b*8 +: 8];
        return v;
    endfunction

    function automatic logic [XLEN-1:0] got_rd(input int d, input int p);
        return (d == 0) ? rdata_a[p*XLEN +: XLEN] : rdata_b[p*XLEN +: XLEN];
    endfunction

    // Model state advance at a rising edge, from the inputs held there.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            logic ready;
            ready = !model_busy(d);
            if (model_busy(d) && init_req)
                for (int k = 0; k < cpc[d]; k++) mem[d][ncleared[d] + k] = '0;
            if (ready)
                for (int b = 0; b < NL; b++)
                    if (wr_wen[b]) mem[d][wr_addr][b*8 +: 8] = wr_wdata[b*8 +: 8];
            if (!g_resetn) begin
                st[d] = 0;
                ncleared[d] = 0;
            end else begin
                case (st[d])
                    0: if (init_req) begin st[d] = 1; ncleared[d] = 0; end
                    1: begin
                        if (!init_req) st[d] = 0;
                        else begin
                            ncleared[d] += cpc[d];
                            if (ncleared[d] == NREGS) st[d] = 2;
                        end
                    end
                    default: if (!init_req) st[d] = 0;
                endcase
            end
        end
    endtask

    // Sample all outputs at the falling edge against the model.
    task automatic at_neg();
        logic [XLEN-1:0] e;
        @(negedge g_clk);
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NRD; p++) exp_q.push_back(model_read(d, p));
            exp_q.push_back({31'd0, model_busy(d)});
            exp_q.push_back({31'd0, model_done(d)});
            exp_q.push_back({31'd0, !model_busy(d)});
            exp_q.push_back({31'd0, (|wr_wen) | init_req | model_busy(d) | model_done(d)});
        end
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NRD; p++) begin
                e = exp_q.pop_front();
                check_val($sformatf("d%0d_rd%0d", d, p), got_rd(d, p), e);
            end
            e = exp_q.pop_front();
            check_val($sformatf("d%0d_busy", d), {31'd0, d == 0 ? busy_a : busy_b}, e);
            e = exp_q.pop_front();
            check_val($sformatf("d%0d_done", d), {31'd0, d == 0 ? done_a : done_b}, e);
            e = exp_q.pop_front();
            check_val($sformatf("d%0d_ready", d), {31'd0, d == 0 ? ready_a : ready_b}, e);
            e = exp_q.pop_front();
            check_val($sformatf("d%0d_clkreq", d), {31'd0, d == 0 ? clk_req_a : clk_req_b}, e);
        end
    endtask

    task automatic finish_cycle();
        @(posedge g_clk);
        model_edge();
        #1;
    endtask

    task automatic cycle();
        at_neg();
        finish_cycle();
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        rd_ren   = '0;
        rd_addr  = '0;
        wr_wen   = '0;
        wr_addr  = '0;
        wr_wdata = '0;
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                               input logic [NL-1:0] wen);
        wr_addr  = a;
        wr_wdata = d;
        wr_wen   = wen;
    endtask

    task automatic drive_read(input int p, input logic [AW-1:0] a, input logic en);
        rd_addr[p*AW +: AW] = a;
        rd_ren[p]           = en;
    endtask

    task automatic read_all_ports(input logic [AW-1:0] a);
        for (int p = 0; p < NRD; p++) drive_read(p, a, 1'b1);
    endtask

    task automatic prefill_ones();
        idle_inputs();
        for (int r = 0; r < NREGS; r++) begin
            drive_write(AW'(r), 32'hFFFF_FFFF, 4'hF);
            cycle();
        end
        idle_inputs();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int busy_cnt_a, busy_cnt_b;
        for (int d = 0; d < 2; d++) begin
            st[d] = 0;
            ncleared[d] = 0;
            for (int r = 0; r < NREGS; r++) mem[d][r] = 'x;
        end
        g_resetn = 1'b0;
        init_req = 1'b0;
        idle_inputs();

        // Reset state
        for (int i = 0; i < 3; i++) begin
            at_neg();
            check_val("rst_ready", {31'd0, ready_a}, 32'd1);
            check_val("rst_clkreq", {31'd0, clk_req_a}, 32'd0);
            check_val("rst_busy", {31'd0, busy_a}, 32'd0);
            finish_cycle();
        end
        g_resetn = 1'b1;

        // 1. Full init: busy for exactly NREGS/CLR_PER_CYC cycles
        init_req = 1'b1;
        busy_cnt_a = 0;
        busy_cnt_b = 0;
        for (int i = 0; i < 18; i++) begin
            at_neg();
            if (busy_a) busy_cnt_a++;
            if (busy_b) busy_cnt_b++;
            finish_cycle();
        end
        check_val("init_busy_cycles_a", busy_cnt_a, 32'd16);
        check_val("init_busy_cycles_b", busy_cnt_b, 32'd4);
        for (int r = 0; r < NREGS; r++) begin
            read_all_ports(AW'(r));
            at_neg();
            if (r == 0) check_val("init_done_a", {31'd0, done_a}, 32'd1);
            for (int p = 0; p < NRD; p++) check_val("init_zero", got_rd(0, p), 32'd0);
            finish_cycle();
        end
        init_req = 1'b0;
        idle_inputs();
        cycle();

        // 2. Byte-lane write
        drive_write(4'd5, 32'hDEAD_BEEF, 4'b0101);
        cycle();
        idle_inputs();
        drive_read(0, 4'd5, 1'b1);
        drive_read(1, 4'd5, 1'b0);
        drive_read(2, 4'd5, 1'b0);
        at_neg();
        check_val("lane_wr_a", got_rd(0, 0), 32'h00AD_00EF);
        check_val("lane_wr_b", got_rd(1, 0), 32'h00AD_00EF);
        check_val("ren_off", got_rd(0, 1), 32'd0);
        finish_cycle();

        // 3. Bypass
        idle_inputs();
        drive_write(4'd3, 32'h1122_3344, 4'hF);
        cycle();
        drive_write(4'd3, 32'hAABB_CCDD, 4'b1000);
        drive_read(1, 4'd3, 1'b1);
        at_neg();
        check_val("bypass_on", got_rd(0, 1), 32'hAA22_3344);
        check_val("bypass_off", got_rd(1, 1), 32'h1122_3344);
        finish_cycle();
        idle_inputs();

        // 4. Write during clear is dropped
        init_req = 1'b1;
        cycle();
        drive_write(4'd7, 32'h1234_5678, 4'hF);
        at_neg();
        check_val("busy_ready_a", {31'd0, ready_a}, 32'd0);
        finish_cycle();
        idle_inputs();
        for (int i = 0; i < 17; i++) cycle();
        read_all_ports(4'd7);
        at_neg();
        check_val("drop_a", got_rd(0, 0), 32'd0);
        check_val("drop_b", got_rd(1, 0), 32'd0);
        finish_cycle();
        init_req = 1'b0;
        idle_inputs();
        cycle();

        // 5. Abort after 4 clear cycles
        prefill_ones();
        init_req = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        init_req = 1'b0;
        at_neg();
        check_val("abort_busy", {31'd0, busy_a}, 32'd1);
        finish_cycle();
        at_neg();
        check_val("abort_idle", {31'd0, busy_a}, 32'd0);
        finish_cycle();
        for (int r = 0; r < NREGS; r++) begin
            read_all_ports(AW'(r));
            at_neg();
            check_val("abort_reg_a", got_rd(0, 0), (r < 4) ? 32'd0 : 32'hFFFF_FFFF);
            finish_cycle();
        end
        idle_inputs();

        // 6. Reset in the middle of a clear
        prefill_ones();
        init_req = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        g_resetn = 1'b0;
        cycle();
        g_resetn = 1'b1;
        init_req = 1'b0;
        at_neg();
        check_val("rst_mid_busy_b", {31'd0, busy_b}, 32'd0);
        finish_cycle();
        read_all_ports(4'd7);
        at_neg();
        check_val("rst_mid_r7_b", got_rd(1, 0), 32'd0);
        finish_cycle();
        read_all_ports(4'd8);
        at_neg();
        check_val("rst_mid_r8_b", got_rd(1, 0), 32'hFFFF_FFFF);
        finish_cycle();

        // Full init again so every register is defined, then random traffic
        idle_inputs();
        init_req = 1'b1;
        for (int i = 0; i < 18; i++) cycle();
        init_req = 1'b0;
        cycle();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) init_req = ~init_req;
            wr_addr  = AW'($urandom_range(0, NREGS - 1));
            wr_wdata = $urandom;
            wr_wen   = ($urandom_range(0, 1) == 0) ? 4'h0 : NL'($urandom_range(0, 15));
            for (int p = 0; p < NRD; p++) begin
                logic [AW-1:0] a;
                a = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, NREGS - 1));
                drive_read(p, a, 1'($urandom_range(0, 3) != 0));
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
